tone_decoder: RTL and testbench

TONE_DECODER -- requirements
Module: tone_decoder

---
 rtl/tone_decoder.sv | 197 +++++++++++++++++++
 tb/tb_tone_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_decoder.sv
// Tone decoder: synchronizes a square-wave input, measures half-periods,
// classifies them as tone A / tone B and reports timed tone segments.
//
// state     | meaning
// ST_SILENT | no recent input edges, waiting for a first edge
// ST_ARM    | edges seen, waiting for a classifiable half-period
// ST_CAND   | one A/B half-period seen, candidate recorded
// ST_LOCKED | two matching half-periods, tone committed
module tone_decoder #(
  parameter int P_HALF_A  = 125_000,
  parameter int P_HALF_B  = 50_000,
  parameter int P_TOL     = 2_000,
  parameter int P_SILENCE = 250_000,
  parameter int P_UNIT    = 12_500_000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSOUND,
  output logic [1:0] oTONE,
  output logic       oLOCK,
  output logic       oEVT,
  output logic [1:0] oEVT_TONE,
  output logic [3:0] oEVT_DUR
);

  localparam logic [1:0]  TONE_SIL = 2'd0;
  localparam logic [1:0]  TONE_A   = 2'd1;
  localparam logic [1:0]  TONE_B   = 2'd2;
  localparam logic [1:0]  CLS_UNK  = 2'd0;

  localparam logic [21:0] LP_A_LO  = 22'(P_HALF_A - P_TOL);
  localparam logic [21:0] LP_A_HI  = 22'(P_HALF_A + P_TOL);
  localparam logic [21:0] LP_B_LO  = 22'(P_HALF_B - P_TOL);
  localparam logic [21:0] LP_B_HI  = 22'(P_HALF_B + P_TOL);
  localparam logic [20:0] LP_SIL   = 21'(P_SILENCE);
  localparam logic [23:0] LP_UMAX  = 24'(P_UNIT - 1);

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_ARM    = 2'd1,
    ST_CAND   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic        r_edge;
  logic [20:0] r_hcnt;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cand;
  logic [1:0]  w_cand_nxt;
  logic [1:0]  r_tone;
  logic        r_evt;
  logic [1:0]  r_evt_tone;
  logic [3:0]  r_evt_dur;
  logic [23:0] r_presc;
  logic [3:0]  r_units;

  logic [21:0] w_hper;
  logic        w_is_a;
  logic        w_is_b;
  logic [1:0]  w_class;
  logic        w_timeout;
  logic        w_commit;
  logic [1:0]  w_commit_tone;
  logic        w_evt_fire;
  logic        w_presc_wrap;
  logic [3:0]  w_units_now;

  // r_sync3 holds the previous synchronized level; the strobe is registered
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= iSOUND;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 ^ r_sync3;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_hcnt <= 21'd0;
    end else if (r_edge) begin
      r_hcnt <= 21'd0;
    end else if (r_hcnt != LP_SIL) begin
      r_hcnt <= r_hcnt + 21'd1;
    end
  end

  // The strobe cycle itself closes the half-period, hence the +1
  assign w_hper  = {1'b0, r_hcnt} + 22'd1;
  assign w_is_a  = (w_hper >= LP_A_LO) && (w_hper <= LP_A_HI);
  assign w_is_b  = (w_hper >= LP_B_LO) && (w_hper <= LP_B_HI);
  assign w_class = w_is_a ? TONE_A : (w_is_b ? TONE_B : CLS_UNK);

  assign w_timeout = (r_state != ST_SILENT) && (r_hcnt == LP_SIL);

  always_comb begin
    w_state_nxt   = r_state;
    w_cand_nxt    = r_cand;
    w_commit      = 1'b0;
    w_commit_tone = r_tone;
    if (w_timeout) begin
      w_state_nxt   = ST_SILENT;
      w_commit      = 1'b1;
      w_commit_tone = TONE_SIL;
    end else if (r_edge) begin
      case (r_state)
        ST_SILENT: begin
          w_state_nxt = ST_ARM;
        end
        ST_ARM: begin
          if (w_class != CLS_UNK) begin
            w_state_nxt = ST_CAND;
            w_cand_nxt  = w_class;
          end
        end
        ST_CAND: begin
          if (w_class == CLS_UNK) begin
            w_state_nxt = ST_ARM;
          end else if (w_class == r_cand) begin
            w_state_nxt   = ST_LOCKED;
            w_commit      = 1'b1;
            w_commit_tone = r_cand;
          end else begin
            w_cand_nxt = w_class;
          end
        end
        ST_LOCKED: begin
          if (w_class == CLS_UNK) begin
            w_state_nxt = ST_ARM;
          end else if (w_class != r_tone) begin
            w_state_nxt = ST_CAND;
            w_cand_nxt  = w_class;
          end
        end
        default: begin
          w_state_nxt = ST_SILENT;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= ST_SILENT;
      r_cand  <= CLS_UNK;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  // A wrap landing on the event cycle still counts toward the reported length
  assign w_presc_wrap = (r_presc == LP_UMAX);
  assign w_units_now  = (w_presc_wrap && (r_units != 4'd15)) ? r_units + 4'd1 : r_units;
  assign w_evt_fire   = w_commit && (w_commit_tone != r_tone);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_tone     <= TONE_SIL;
      r_evt      <= 1'b0;
      r_evt_tone <= TONE_SIL;
      r_evt_dur  <= 4'd0;
      r_presc    <= 24'd0;
      r_units    <= 4'd0;
    end else begin
      r_evt <= w_evt_fire;
      if (w_evt_fire) begin
        r_tone     <= w_commit_tone;
        r_evt_tone <= r_tone;
        r_evt_dur  <= w_units_now;
        r_presc    <= 24'd0;
        r_units    <= 4'd0;
      end else if (w_presc_wrap) begin
        r_presc <= 24'd0;
        r_units <= w_units_now;
      end else begin
        r_presc <= r_presc + 24'd1;
      end
    end
  end

  assign oTONE     = r_tone;
  assign oLOCK     = (r_state == ST_LOCKED);
  assign oEVT      = r_evt;
  assign oEVT_TONE = r_evt_tone;
  assign oEVT_DUR  = r_evt_dur;

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder with scaled-down timing parameters; a timestamp-level
// model of the decoding rules is compared against the outputs every cycle.
module tb_tone_decoder;

  localparam int HA   = 125;
  localparam int HB   = 50;
  localparam int TOL  = 2;
  localparam int SIL  = 250;
  localparam int UNIT = 1250;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic       iSOUND;
  logic [1:0] oTONE;
  logic       oLOCK;
  logic       oEVT;
  logic [1:0] oEVT_TONE;
  logic [3:0] oEVT_DUR;

  always #5 iCLK = ~iCLK;

  tone_decoder #(
    .P_HALF_A (HA),
    .P_HALF_B (HB),
    .P_TOL    (TOL),
    .P_SILENCE(SIL),
    .P_UNIT   (UNIT)
  ) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iSOUND   (iSOUND),
    .oTONE    (oTONE),
    .oLOCK    (oLOCK),
    .oEVT     (oEVT),
    .oEVT_TONE(oEVT_TONE),
    .oEVT_DUR (oEVT_DUR)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int q[$];

  // model: phase 0 silent, 1 armed, 2 candidate, 3 locked
  int m_st, m_cand, m_tone, m_evt, m_evt_tone, m_evt_dur, m_last, m_seg;
  int obs_cnt = 0, obs_tone = 0, obs_dur = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
      if (failures >= 50) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  endtask

  function automatic int classify(input int h);
    if (h >= HA - TOL && h <= HA + TOL) return 1;
    if (h >= HB - TOL && h <= HB + TOL) return 2;
    return 0;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_cand = 0; m_tone = 0;
    m_evt = 0; m_evt_tone = 0; m_evt_dur = 0;
  endfunction

  // n is the clock edge index at which the decoder acts
  function automatic void model_step(input int n);
    bit strobe;
    int h, c, nt;
    strobe = (q.size() > 0) && (q[0] == n);
    if (strobe) void'(q.pop_front());
    h     = n - m_last;
    nt    = -1;
    m_evt = 0;
    if (m_st != 0 && h >= SIL + 1) begin
      m_st = 0;
      nt   = 0;
    end else if (strobe) begin
      c = classify(h);
      if (m_st == 0) m_st = 1;
      else if (m_st == 1) begin
        if (c != 0) begin m_st = 2; m_cand = c; end
      end else if (m_st == 2) begin
        if (c == 0) m_st = 1;
        else if (c == m_cand) begin m_st = 3; nt = c; end
        else m_cand = c;
      end else begin
        if (c == 0) m_st = 1;
        else if (c != m_tone) begin m_st = 2; m_cand = c; end
      end
    end
    if (strobe) m_last = n;
    if (nt >= 0 && nt != m_tone) begin
      m_evt      = 1;
      m_evt_tone = m_tone;
      m_evt_dur  = ((n - m_seg) / UNIT > 15) ? 15 : (n - m_seg) / UNIT;
      m_seg      = n;
      m_tone     = nt;
    end
  endfunction

  always @(posedge iCLK) begin
    cyc = cyc + 1;
    if (iRST_N === 1'b1) model_step(cyc);
    #1;
    chk("tone", 32'(oTONE), m_tone);
    chk("lock", 32'(oLOCK), (m_st == 3) ? 1 : 0);
    chk("evt", 32'(oEVT), m_evt);
    chk("evt_tone", 32'(oEVT_TONE), m_evt_tone);
    chk("evt_dur", 32'(oEVT_DUR), m_evt_dur);
    if (oEVT === 1'b1) begin
      obs_cnt++;
      obs_tone = int'(oEVT_TONE);
      obs_dur  = int'(oEVT_DUR);
    end
  end

  // wait h cycles, then toggle the input; called at a negedge
  task automatic edge_in(input int h);
    repeat (h) @(negedge iCLK);
    iSOUND = ~iSOUND;
    q.push_back(cyc + 4);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic do_reset(input int hold);
    #2;
    iRST_N = 1'b0;
    model_reset();
    q.delete();
    #1;
    chk("rst_tone", 32'(oTONE), 0);
    chk("rst_lock", 32'(oLOCK), 0);
    chk("rst_evt", 32'(oEVT), 0);
    chk("rst_evt_tone", 32'(oEVT_TONE), 0);
    chk("rst_evt_dur", 32'(oEVT_DUR), 0);
    iSOUND = 1'b0;
    repeat (hold) @(negedge iCLK);
    iRST_N = 1'b1;
    m_seg  = cyc;
    m_last = cyc;
  endtask

  function automatic int jitter(input int base);
    return base + int'($urandom_range(0, 8)) - 4;
  endfunction

  initial begin
    int e0, mode, len, h;
    iRST_N = 1'b0;
    iSOUND = 1'b0;
    model_reset();
    m_seg  = 0;
    m_last = 0;
    idle(3);
    chk("init_tone", 32'(oTONE), 0);
    chk("init_lock", 32'(oLOCK), 0);
    chk("init_evt_dur", 32'(oEVT_DUR), 0);
    iRST_N = 1'b1;
    m_seg  = cyc;
    m_last = cyc;

    // tone A from silence locks on the third edge
    e0 = obs_cnt;
    edge_in(1); edge_in(HA); edge_in(HA); edge_in(HA);
    chk("a_lock_tone", 32'(oTONE), 1);
    chk("a_lock_lock", 32'(oLOCK), 1);
    chk("a_lock_evtcnt", 32'(obs_cnt - e0), 1);
    chk("a_lock_evt_tone", 32'(obs_tone), 0);
    chk("a_lock_evt_dur", 32'(obs_dur), 0);

    // A held two units, then switch to B
    repeat (19) edge_in(HA);
    edge_in(HB); edge_in(HB);
    chk("ab_cand_lock", 32'(oLOCK), 0);
    chk("ab_cand_tone", 32'(oTONE), 1);
    edge_in(HB);
    chk("b_lock_tone", 32'(oTONE), 2);
    chk("b_lock_evt_tone", 32'(obs_tone), 1);
    chk("b_lock_evt_dur", 32'(obs_dur), 2);

    // constant input: silence declared on the exact cycle
    e0 = obs_cnt;
    idle(254);
    chk("sil_before_tone", 32'(oTONE), 2);
    idle(1);
    chk("sil_tone", 32'(oTONE), 0);
    chk("sil_lock", 32'(oLOCK), 0);
    chk("sil_evtcnt", 32'(obs_cnt - e0), 1);
    chk("sil_evt_tone", 32'(obs_tone), 2);

    // inclusive tolerance limits around A
    e0 = obs_cnt;
    edge_in(10); edge_in(HA + TOL); edge_in(HA + TOL); edge_in(HA + TOL + 1);
    chk("hi_lim_lock", 32'(oLOCK), 1);
    edge_in(HA);
    chk("hi_over_lock", 32'(oLOCK), 0);
    chk("hi_over_tone", 32'(oTONE), 1);
    edge_in(HA); edge_in(HA); edge_in(HA - TOL); edge_in(HA - TOL - 1);
    chk("lo_lim_lock", 32'(oLOCK), 1);
    edge_in(HA);
    chk("lo_over_lock", 32'(oLOCK), 0);
    edge_in(HA); edge_in(HA);
    chk("relock_evtcnt", 32'(obs_cnt - e0), 1);

    // single glitch inside tone A
    e0 = obs_cnt;
    edge_in(80); edge_in(HA);
    chk("glitch_lock", 32'(oLOCK), 0);
    chk("glitch_tone", 32'(oTONE), 1);
    edge_in(HA); edge_in(HA); edge_in(HA);
    chk("glitch_relock", 32'(oLOCK), 1);
    chk("glitch_evtcnt", 32'(obs_cnt - e0), 0);

    // long A segment saturates the duration
    repeat (165) edge_in(HA);
    idle(300);
    chk("sat_tone", 32'(oTONE), 0);
    chk("sat_evt_tone", 32'(obs_tone), 1);
    chk("sat_evt_dur", 32'(obs_dur), 15);

    // reset mid-tone discards the segment
    edge_in(5); edge_in(HA); edge_in(HA);
    repeat (10) edge_in(HA);
    e0 = obs_cnt;
    do_reset(5);
    idle(20);
    chk("rst_no_evt", 32'(obs_cnt - e0), 0);
    edge_in(3); edge_in(HB); edge_in(HB); edge_in(HB);
    chk("post_rst_tone", 32'(oTONE), 2);
    chk("post_rst_evt_tone", 32'(obs_tone), 0);

    // randomized segments
    for (int s = 0; s < 40; s++) begin
      if (s == 20) begin
        idle(int'($urandom_range(1, 40)));
        do_reset(3);
      end
      mode = int'($urandom_range(0, 9));
      len  = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        if (mode < 4) h = jitter(HA);
        else if (mode < 7) h = jitter(HB);
        else if (mode < 9) h = int'($urandom_range(8, 300));
        else h = SIL + int'($urandom_range(0, 1));
        edge_in(h);
      end
    end
    idle(300);
    chk("final_tone", 32'(oTONE), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
